// File: rtl/regbank_pkg.sv
// Shared constants, state/source encodings and the stage-1 access record for regbank_arbiter.
// onehot() maps a binary register index to a bank select and yields 0 for out-of-range indices.
package regbank_pkg;

  localparam int NUM_REGS = 10;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;

  typedef enum logic [1:0] {IDLE, DRAIN, RD, HOLD} state_t;
  typedef enum logic {SRC_HOST, SRC_LOCAL} src_t;

  typedef struct packed {
    logic              vld;
    logic              we;
    src_t              src;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] idx);
    logic [NUM_REGS-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = (idx == ADDR_W'(i));
    end
    return sel;
  endfunction

endpackage

// File: rtl/regbank_arbiter_rr_arb2.sv
// Two-way round-robin arbiter, grant is combinational (0 cycles); en=0 holds every request off.
// Bit 0 is host, bit 1 is local; ties go to whichever side was not granted last, host after reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_local;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = prio_local ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      prio_local <= 1'b0;
    else if (gnt[0]) prio_local <= 1'b1;
    else if (gnt[1]) prio_local <= 1'b0;
  end

endmodule

// File: rtl/regbank_arbiter.sv
// Register-bank controller: grant at N, bank access at N+1, read response at N+2; dump streams one word per 2 cycles.
// Requests are held off (not dropped) while a dump runs; dump_ready=0 freezes the current word. Option: REGBANK_ERR_EN.
module regbank_arbiter
  import regbank_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                h_req,
  input  logic                h_we,
  input  logic [ADDR_W-1:0]   h_addr,
  input  logic [DATA_W-1:0]   h_wdata,
  output logic                h_gnt,
  output logic                h_rvalid,
  output logic [DATA_W-1:0]   h_rdata,
  input  logic                l_req,
  input  logic                l_we,
  input  logic [ADDR_W-1:0]   l_addr,
  input  logic [DATA_W-1:0]   l_wdata,
  output logic                l_gnt,
  output logic                l_rvalid,
  output logic [DATA_W-1:0]   l_rdata,
  output logic [NUM_REGS-1:0] wsel,
  output logic [NUM_REGS-1:0] rsel,
  output logic [DATA_W-1:0]   din,
  input  logic [DATA_W-1:0]   dout,
  input  logic                dump_start,
  output logic                dump_busy,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [ADDR_W-1:0]   dump_idx,
  output logic [DATA_W-1:0]   dump_data
`ifdef REGBANK_ERR_EN
  ,
  output logic                h_err,
  output logic                l_err
`endif
);

  state_t              state, nxt;
  acc_t                s1;
  logic [1:0]          gnt;
  logic                arb_en;
  logic                s1_rd;
  logic [NUM_REGS-1:0] s1_sel, rd_sel;
  logic [DATA_W-1:0]   rd_word;
  logic [ADDR_W-1:0]   idx;
  logic                idx_last;

  // reset is in the enable so grants read 0 while reset is asserted
  assign arb_en = reset && (state == IDLE) && !dump_start;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   ({l_req, h_req}),
    .gnt   (gnt)
  );

  assign h_gnt = gnt[0];
  assign l_gnt = gnt[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      s1 <= '0;
    else if (gnt[1]) s1 <= '{vld: 1'b1, we: l_we, src: SRC_LOCAL, addr: l_addr, wdata: l_wdata};
    else if (gnt[0]) s1 <= '{vld: 1'b1, we: h_we, src: SRC_HOST, addr: h_addr, wdata: h_wdata};
    else             s1 <= '0;
  end

  assign s1_sel  = s1.vld ? onehot(s1.addr) : '0;
  assign s1_rd   = s1.vld && !s1.we;
  assign rd_sel  = s1_rd ? s1_sel : '0;
  assign wsel    = s1.we ? s1_sel : '0;
  assign din     = (s1.vld && s1.we) ? s1.wdata : '0;
  assign rsel    = rd_sel | ((state == RD) ? onehot(idx) : '0);
  assign rd_word = (|rd_sel) ? dout : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
      h_rdata  <= '0;
      l_rdata  <= '0;
    end else begin
      h_rvalid <= s1_rd && (s1.src == SRC_HOST);
      l_rvalid <= s1_rd && (s1.src == SRC_LOCAL);
      if (s1_rd && (s1.src == SRC_HOST))  h_rdata <= rd_word;
      if (s1_rd && (s1.src == SRC_LOCAL)) l_rdata <= rd_word;
    end
  end

`ifdef REGBANK_ERR_EN
  logic s1_oor;
  assign s1_oor = s1.vld && (s1.addr >= ADDR_W'(NUM_REGS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_err <= 1'b0;
      l_err <= 1'b0;
    end else begin
      h_err <= s1_oor && (s1.src == SRC_HOST);
      l_err <= s1_oor && (s1.src == SRC_LOCAL);
    end
  end
`endif

  assign idx_last = (idx == ADDR_W'(NUM_REGS - 1));
  assign dump_idx = idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt        = state;
    dump_busy  = 1'b1;
    dump_valid = 1'b0;
    case (state)
      IDLE: begin
        dump_busy = 1'b0;
        if (dump_start) nxt = DRAIN;
      end
      DRAIN: nxt = RD;
      RD:    nxt = HOLD;
      HOLD: begin
        dump_valid = 1'b1;
        if (dump_ready) nxt = idx_last ? IDLE : RD;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      dump_data <= '0;
    end else begin
      case (state)
        DRAIN: idx <= '0;
        RD:    dump_data <= dout;
        HOLD:  if (dump_ready) idx <= idx_last ? '0 : idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: directed vector table, dump sequences, and randomized traffic against a behavioural model.
module tb_regbank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        h_req, h_we, l_req, l_we;
  logic [3:0]  h_addr, l_addr;
  logic [31:0] h_wdata, l_wdata;
  logic        h_gnt, h_rvalid, l_gnt, l_rvalid;
  logic [31:0] h_rdata, l_rdata;
  logic [9:0]  wsel, rsel;
  logic [31:0] din, dout;
  logic        dump_start, dump_busy, dump_valid, dump_ready;
  logic [3:0]  dump_idx;
  logic [31:0] dump_data;
`ifdef REGBANK_ERR_EN
  logic        h_err, l_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regbank_arbiter dut (
    .clk(clk), .reset(reset),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .wsel(wsel), .rsel(rsel), .din(din), .dout(dout),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data)
`ifdef REGBANK_ERR_EN
    , .h_err(h_err), .l_err(l_err)
`endif
  );

  // the register bank itself lives in the bench
  logic [31:0] bank [10] = '{default: 32'h0};
  always @(posedge clk) begin
    for (int i = 0; i < 10; i++) if (wsel[i]) bank[i] <= din;
  end
  always_comb begin
    dout = 32'h0;
    for (int i = 0; i < 10; i++) if (rsel[i]) dout = dout | bank[i];
  end

  logic outs_or;
  always_comb begin
    outs_or = |{h_gnt, l_gnt, h_rvalid, l_rvalid, h_rdata, l_rdata, wsel, rsel, din,
                dump_busy, dump_valid, dump_idx, dump_data};
`ifdef REGBANK_ERR_EN
    outs_or = outs_or | h_err | l_err;
`endif
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic hr, hw; logic [3:0] ha; logic [31:0] hd;
    logic lr, lw; logic [3:0] la; logic [31:0] ld;
    logic [1:0] e_gnt; logic [9:0] e_ws, e_rs; logic [31:0] e_din;
    logic [1:0] e_rv; logic [31:0] e_hq, e_lq; logic e_herr;
  } vec_t;

  function automatic vec_t mk(input logic hr, input logic hw, input logic [3:0] ha, input logic [31:0] hd,
                              input logic lr, input logic lw, input logic [3:0] la, input logic [31:0] ld,
                              input logic [1:0] eg, input logic [9:0] ews, input logic [9:0] ers,
                              input logic [31:0] edin, input logic [1:0] erv, input logic [31:0] ehq,
                              input logic [31:0] elq, input logic eherr);
    vec_t v;
    v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd; v.lr = lr; v.lw = lw; v.la = la; v.ld = ld;
    v.e_gnt = eg; v.e_ws = ews; v.e_rs = ers; v.e_din = edin; v.e_rv = erv;
    v.e_hq = ehq; v.e_lq = elq; v.e_herr = eherr;
    return v;
  endfunction

  vec_t vecs [17];
  logic [31:0] mdl [10] = '{default: 32'h0};

  typedef struct { int cyc; logic local_src; logic rd; logic err; logic [31:0] data; } rsp_t;
  rsp_t rq[$];

  task automatic run_dump(input int stall_idx, input int abort_idx);
    int  words = 0;
    int  busy = 0;
    int  stalled = 0;
    logic done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      dump_start = (c == 0); dump_ready = 1'b1;
      h_req = 1'b1; h_we = 1'b0; h_addr = 4'd0;
      #1;
      if (c > 0 && !dump_busy) begin
        chk("gnt_after_dump", 64'(h_gnt), 64'd1);
        chk("busy_cycles", 64'(busy), 64'(21 + ((stall_idx >= 0) ? 5 : 0)));
        chk("dump_words", 64'(words), 64'd10);
        done = 1'b1;
      end else begin
        chk("gnt_held_off", 64'({h_gnt, l_gnt}), 64'd0);
        if (dump_busy) busy++;
        if (dump_valid) begin
          chk("dump_idx", 64'(dump_idx), 64'(words));
          chk("dump_data", 64'(dump_data), 64'(32'h100 + words));
          if (words == abort_idx) begin
            reset = 1'b0;
            #1;
            chk("abort_outputs_zero", 64'(outs_or), 64'd0);
            done = 1'b1;
          end else if (words == stall_idx && stalled < 5) begin
            dump_ready = 1'b0;
            stalled++;
          end else begin
            words++;
          end
        end
      end
    end
    chk("dump_terminated", 64'(done), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  eg, erv;
    logic [31:0] ehq, elq;
    logic [1:0]  eerr;
    logic        last_host;
    logic        sw;
    logic [3:0]  sa;
    logic [31:0] sd;

    //          hr    hw    ha     hd             lr    lw    la     ld            gnt    wsel      rsel      din            rv     hq             lq             herr
    vecs[0]  = mk(1'b1, 1'b1, 4'd3,  32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 32'h0,  2'b10, 10'h000, 10'h000, 32'h0,        2'b00, 32'h0,        32'h0,        1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 4'd3,  32'h0,        1'b0, 1'b0, 4'd0, 32'h0,  2'b10, 10'h008, 10'h000, 32'hDEADBEEF, 2'b00, 32'h0,        32'h0,        1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd0, 32'h0,  2'b00, 10'h000, 10'h008, 32'h0,        2'b00, 32'h0,        32'h0,        1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd0, 32'h0,  2'b00, 10'h000, 10'h000, 32'h0,        2'b10, 32'hDEADBEEF, 32'h0,        1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 4'd0,  32'h0,        1'b1, 1'b1, 4'd5, 32'h55, 2'b01, 10'h000, 10'h000, 32'h0,        2'b00, 32'h0,        32'h0,        1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 4'd5,  32'h0,        1'b1, 1'b0, 4'd3, 32'h0,  2'b10, 10'h020, 10'h000, 32'h55,       2'b00, 32'h0,        32'h0,        1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 4'd5,  32'h0,        1'b1, 1'b0, 4'd3, 32'h0,  2'b01, 10'h000, 10'h020, 32'h0,        2'b00, 32'h0,        32'h0,        1'b0);
    vecs[7]  = mk(1'b1, 1'b0, 4'd5,  32'h0,        1'b1, 1'b0, 4'd3, 32'h0,  2'b10, 10'h000, 10'h008, 32'h0,        2'b10, 32'h55,       32'h0,        1'b0);
    vecs[8]  = mk(1'b1, 1'b0, 4'd5,  32'h0,        1'b1, 1'b0, 4'd3, 32'h0,  2'b01, 10'h000, 10'h020, 32'h0,        2'b01, 32'h0,        32'hDEADBEEF, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd0, 32'h0,  2'b00, 10'h000, 10'h008, 32'h0,        2'b10, 32'h55,       32'h0,        1'b0);
    vecs[10] = mk(1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd0, 32'h0,  2'b00, 10'h000, 10'h000, 32'h0,        2'b01, 32'h0,        32'hDEADBEEF, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd0, 32'h0,  2'b00, 10'h000, 10'h000, 32'h0,        2'b00, 32'h0,        32'h0,        1'b0);
    vecs[12] = mk(1'b1, 1'b1, 4'd12, 32'h12345678, 1'b0, 1'b0, 4'd0, 32'h0,  2'b10, 10'h000, 10'h000, 32'h0,        2'b00, 32'h0,        32'h0,        1'b0);
    vecs[13] = mk(1'b1, 1'b0, 4'd12, 32'h0,        1'b0, 1'b0, 4'd0, 32'h0,  2'b10, 10'h000, 10'h000, 32'h12345678, 2'b00, 32'h0,        32'h0,        1'b0);
    vecs[14] = mk(1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd0, 32'h0,  2'b00, 10'h000, 10'h000, 32'h0,        2'b00, 32'h0,        32'h0,        1'b1);
    vecs[15] = mk(1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd0, 32'h0,  2'b00, 10'h000, 10'h000, 32'h0,        2'b10, 32'h0,        32'h0,        1'b1);
    vecs[16] = mk(1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd0, 32'h0,  2'b00, 10'h000, 10'h000, 32'h0,        2'b00, 32'h0,        32'h0,        1'b0);

    reset = 1'b0;
    h_req = 1'b0; h_we = 1'b0; h_addr = 4'd0; h_wdata = 32'h0;
    l_req = 1'b0; l_we = 1'b0; l_addr = 4'd0; l_wdata = 32'h0;
    dump_start = 1'b0; dump_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs_zero", 64'(outs_or), 64'd0);
    reset = 1'b1;

    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      h_req = vecs[k].hr; h_we = vecs[k].hw; h_addr = vecs[k].ha; h_wdata = vecs[k].hd;
      l_req = vecs[k].lr; l_we = vecs[k].lw; l_addr = vecs[k].la; l_wdata = vecs[k].ld;
      #1;
      chk($sformatf("vec%0d_gnt", k),  64'({h_gnt, l_gnt}), 64'(vecs[k].e_gnt));
      chk($sformatf("vec%0d_wsel", k), 64'(wsel), 64'(vecs[k].e_ws));
      chk($sformatf("vec%0d_rsel", k), 64'(rsel), 64'(vecs[k].e_rs));
      chk($sformatf("vec%0d_din", k),  64'(din), 64'(vecs[k].e_din));
      chk($sformatf("vec%0d_rvalid", k), 64'({h_rvalid, l_rvalid}), 64'(vecs[k].e_rv));
      if (vecs[k].e_rv[1]) chk($sformatf("vec%0d_h_rdata", k), 64'(h_rdata), 64'(vecs[k].e_hq));
      if (vecs[k].e_rv[0]) chk($sformatf("vec%0d_l_rdata", k), 64'(l_rdata), 64'(vecs[k].e_lq));
`ifdef REGBANK_ERR_EN
      chk($sformatf("vec%0d_err", k), 64'({h_err, l_err}), 64'({vecs[k].e_herr, 1'b0}));
`endif
    end

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      h_req = 1'b1; h_we = 1'b1; h_addr = 4'(i); h_wdata = 32'h100 + 32'(i);
      #1;
      chk("preload_gnt", 64'(h_gnt), 64'd1);
      mdl[i] = 32'h100 + 32'(i);
    end
    @(negedge clk); h_req = 1'b0;
    repeat (2) @(negedge clk);

    run_dump(-1, -1);
    @(negedge clk); h_req = 1'b0; dump_ready = 1'b1;
    repeat (3) @(negedge clk);

    run_dump(4, -1);
    @(negedge clk); h_req = 1'b0;
    repeat (3) @(negedge clk);

    run_dump(-1, 6);
    @(negedge clk); h_req = 1'b0;
    #1;
    chk("abort_still_zero", 64'(outs_or), 64'd0);
    @(negedge clk);
    reset = 1'b1; h_req = 1'b1; h_we = 1'b0; h_addr = 4'd0;
    #1;
    chk("gnt_after_reset", 64'(h_gnt), 64'd1);
    chk("idle_after_reset", 64'(dump_busy), 64'd0);
    @(negedge clk); h_req = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) chk($sformatf("bank%0d_kept", i), 64'(bank[i]), 64'(mdl[i]));

    last_host = 1'b1;
    for (int c = 0; c < 320; c++) begin
      @(negedge clk);
      h_req = (c < 300) && ($urandom_range(0, 9) < 6);
      l_req = (c < 300) && ($urandom_range(0, 9) < 6);
      h_we = 1'($urandom_range(0, 1)); l_we = 1'($urandom_range(0, 1));
      h_addr = 4'($urandom_range(0, 11)); l_addr = 4'($urandom_range(0, 11));
      h_wdata = $urandom; l_wdata = $urandom;
      #1;
      if (h_req && l_req) eg = last_host ? 2'b01 : 2'b10;
      else                eg = {h_req, l_req};
      chk("rand_gnt", 64'({h_gnt, l_gnt}), 64'(eg));

      erv = 2'b00; ehq = 32'h0; elq = 32'h0; eerr = 2'b00;
      while (rq.size() > 0 && rq[0].cyc == c) begin
        rsp_t r;
        r = rq.pop_front();
        if (r.local_src) begin
          erv[0] = r.rd; elq = r.data; eerr[0] = r.err;
        end else begin
          erv[1] = r.rd; ehq = r.data; eerr[1] = r.err;
        end
      end
      chk("rand_rvalid", 64'({h_rvalid, l_rvalid}), 64'(erv));
      if (erv[1]) chk("rand_h_rdata", 64'(h_rdata), 64'(ehq));
      if (erv[0]) chk("rand_l_rdata", 64'(l_rdata), 64'(elq));
`ifdef REGBANK_ERR_EN
      chk("rand_err", 64'({h_err, l_err}), 64'(eerr));
`else
      if (eerr != 2'b00) total = total + 0;
`endif

      if (eg != 2'b00) begin
        sw = eg[0] ? l_we : h_we;
        sa = eg[0] ? l_addr : h_addr;
        sd = eg[0] ? l_wdata : h_wdata;
        last_host = eg[1];
        if (sw && sa < 4'd10) mdl[sa] = sd;
        if (!sw || sa >= 4'd10) begin
          rsp_t r;
          r.cyc = c + 2; r.local_src = eg[0]; r.rd = !sw; r.err = (sa >= 4'd10);
          r.data = (sa < 4'd10) ? mdl[sa] : 32'h0;
          rq.push_back(r);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
Controller for the 10 x 32-bit one-hot-addressed register bank. Shares the bank between two requesters (LPC host side, local agent) using round-robin arbitration. Includes a dump engine that streams all registers, in index order, over a valid/ready port. Drives the bank's wsel/rsel/din and samples its dout.

Parameters:
NUM_REGS, 10, number of bank registers (width of wsel/rsel)
DATA_W, 32, register width
ADDR_W, 4, binary register index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
h_req  in  1  host access request
h_we  in  1  host 1=write, 0=read
h_addr  in  ADDR_W  host register index
h_wdata  in  DATA_W  host write data
h_gnt  out  1  host request accepted this cycle
h_rvalid  out  1  host read data valid (1-cycle pulse)
h_rdata  out  DATA_W  host read data
l_req/l_we/l_addr/l_wdata/l_gnt/l_rvalid/l_rdata  as host ports, local requester
wsel  out  NUM_REGS  one-hot bank write select
rsel  out  NUM_REGS  one-hot bank read select
din  out  DATA_W  bank write data
dout  in  DATA_W  bank read data
dump_start  in  1  start dump (pulse)
dump_busy  out  1  dump in progress
dump_valid  out  1  dump word valid
dump_ready  in  1  dump consumer ready
dump_idx  out  ADDR_W  index of current dump word
dump_data  out  DATA_W  dump word

Behaviour:
- Reset (reset=0, async): all outputs 0; state IDLE; stage-1 empty; round-robin pointer favours host.
- Pipeline:
  - Cycle N: grant. h_gnt/l_gnt are combinational from req and state. At most one grant per cycle.
  - N+1 (stage 1): wsel/rsel/din are driven only from stage-1 registers; no combinational path from any req input. Writes: wsel=onehot(addr), din=wdata; the bank updates at the end of N+1. Reads: rsel=onehot(addr); dout is captured at the end of N+1.
  - N+2: rvalid/rdata (registered) appear on the granted source's port. Writes give no response.
- Back-to-back grants allowed: one access per cycle.
- Read-after-write to the same register in consecutive grants returns the new value; no hazard logic needed.
- Arbitration in IDLE:
  - Single requester is granted.
  - Both requesting: grant the one not granted last. After reset, host wins the first tie.
  - Pointer updates only on a grant.
- Out-of-range addr (>= NUM_REGS): the access is still granted. wsel/rsel stay 0 and the write is dropped. A read returns rdata=0 with rvalid; rdata is forced to 0 whenever stage-1 rsel is 0.
- Dump FSM states: IDLE, DRAIN, RD, HOLD.
  - IDLE: dump_start=1 -> DRAIN. No grant is issued that cycle; dump_start has priority.
  - DRAIN: 1 cycle for the in-flight stage-1 access to complete; idx=0 -> RD.
  - RD: rsel=onehot(idx); dout is captured into dump_data -> HOLD.
  - HOLD: dump_valid=1, dump_data/dump_idx held stable. On dump_ready: if idx==NUM_REGS-1 -> IDLE, else idx+1 -> RD.
- Dump throughput: 1 word per 2 cycles. dump_busy=1 in DRAIN/RD/HOLD.
- h_gnt=l_gnt=0 in every non-IDLE state. Requests are held off, not dropped: requesters keep req high.
- dump_start outside IDLE is ignored.
- Reset mid-dump or mid-access: the operation is aborted. Any pending rvalid is lost; dump_valid drops immediately.

Optional Feature:
REGBANK_ERR_EN
- Defined: adds outputs h_err and l_err (1 bit each). They pulse at N+2 for an out-of-range access, for both reads and writes. For reads they pulse alongside rvalid with rdata=0.
- Undefined: no err ports; out-of-range behaviour otherwise identical.

Decomposition:
- regbank_pkg: NUM_REGS/DATA_W/ADDR_W defaults, state enum {IDLE, DRAIN, RD, HOLD}, source enum {SRC_HOST, SRC_LOCAL}, and an onehot(idx) function returning 0 when out of range.
- Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0] -> gnt[1:0], last-grant pointer, enable input gated by IDLE and !dump_start).

Test Plan:
- Host write addr 3 = 0xDEADBEEF -> h_gnt@N, wsel=10'h008 and din=0xDEADBEEF @N+1. Then host read addr 3 -> h_rvalid@N+2 with 0xDEADBEEF; l_rvalid stays 0.
- Host and local both hold read requests continuously after reset -> grants H,L,H,L...; each rvalid lands 2 cycles after its grant on the correct port.
- Preload reg i=0x100+i, dump_start with dump_ready=1 -> dump_busy high 21 cycles; 10 words, idx 0..9, data 0x100..0x109.
- dump_ready=0 for 5 cycles at idx 4 -> dump_data holds 0x104 and dump_idx holds 4. h_req held high throughout gets h_gnt=0 until dump ends, then is granted.
- Write addr 12 then read addr 12 -> wsel=0, rsel=0, rdata=0 with rvalid. With REGBANK_ERR_EN, h_err pulses for both accesses.
- reset=0 at dump idx 6 -> all outputs 0 immediately. After release: IDLE, the next host request is granted on its first cycle, and bank contents are untouched by the controller.
